uart_rx: RTL and testbench

Serial receiver for the UART link, the counterpart to the team's UART transmitter. It samples an asynchronous 8-N-1 serial line at mid-bit using a clock-divided bit counter, assembles LSB-first bytes and presents each one with a single-cycle valid strobe. It sits between the board RX pin and the byte-level consumer logic, running in the same clock domain as the transmitter and using an identical `CLKS_PER_BIT`.

---
 rtl/uart_rx.sv | 212 +++++++++++++++++++++
 tb/tb_uart_rx.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// uart_rx: 8-N-1 UART receiver with mid-bit sampling, LSB-first assembly and one-cycle strobes.
// Optional even-parity bit enabled by defining UART_RX_PARITY_EN.
`default_nettype none

module uart_rx #(
  parameter int CLKS_PER_BIT = 217
) (
  input  logic       i_Clock,
  input  logic       i_Rst_L,
  input  logic       i_RX_Serial,
  output logic       o_RX_DV,
  output logic [7:0] o_RX_Byte,
  output logic       o_RX_Active,
  output logic       o_RX_Frame_Err,
  output logic       o_RX_Parity_Err
);

  localparam int                 c_CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [c_CNT_W-1:0] c_HALF  = c_CNT_W'((CLKS_PER_BIT - 1) / 2);
  localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(CLKS_PER_BIT - 1);

  localparam logic [2:0] c_IDLE    = 3'd0;
  localparam logic [2:0] c_START   = 3'd1;
  localparam logic [2:0] c_DATA    = 3'd2;
  localparam logic [2:0] c_PARITY  = 3'd3;
  localparam logic [2:0] c_STOP    = 3'd4;
  localparam logic [2:0] c_CLEANUP = 3'd5;

  logic               r_rx_meta;
  logic               r_rx_s;
  logic [2:0]         r_state;
  logic [2:0]         w_next_state;
  logic [c_CNT_W-1:0] r_cnt;
  logic [2:0]         r_idx;
  logic [7:0]         r_shift;
  logic               r_dv;
  logic [7:0]         r_byte;
  logic               r_active;
  logic               r_fe;

  logic w_at_half;
  logic w_at_last;
  logic w_cnt_en;
  logic w_cnt_clr;
  logic w_shift_we;
  logic w_start_ok;
  logic w_stop_sample;
  logic w_par_err;
  logic w_dv_set;
  logic w_fe_set;
  logic w_byte_load;

  assign w_at_half = (r_cnt == c_HALF);
  assign w_at_last = (r_cnt == c_LAST);

  // Two-flop synchronizer; idle-high reset keeps the FSM from seeing a false start bit
  always_ff @(posedge i_Clock or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
    end else begin
      r_rx_meta <= i_RX_Serial;
      r_rx_s    <= r_rx_meta;
    end
  end

  always_ff @(posedge i_Clock or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_IDLE: begin
        if (!r_rx_s) w_next_state = c_START;
      end
      c_START: begin
        if (w_at_half) w_next_state = r_rx_s ? c_IDLE : c_DATA;
      end
      c_DATA: begin
        if (w_at_last && (r_idx == 3'd7)) begin
`ifdef UART_RX_PARITY_EN
          w_next_state = c_PARITY;
`else
          w_next_state = c_STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      c_PARITY: begin
        if (w_at_last) w_next_state = c_STOP;
      end
`endif
      c_STOP: begin
        if (w_at_last) w_next_state = r_rx_s ? c_IDLE : c_CLEANUP;
      end
      c_CLEANUP: begin
        if (r_rx_s) w_next_state = c_IDLE;
      end
      default: w_next_state = c_IDLE;
    endcase
  end

  always_comb begin
    w_cnt_en      = 1'b0;
    w_cnt_clr     = 1'b0;
    w_shift_we    = 1'b0;
    w_start_ok    = 1'b0;
    w_stop_sample = 1'b0;
    case (r_state)
      c_START: begin
        w_cnt_en   = 1'b1;
        w_cnt_clr  = w_at_half;
        w_start_ok = w_at_half && !r_rx_s;
      end
      c_DATA: begin
        w_cnt_en   = 1'b1;
        w_cnt_clr  = w_at_last;
        w_shift_we = w_at_last;
      end
      c_PARITY: begin
        w_cnt_en  = 1'b1;
        w_cnt_clr = w_at_last;
      end
      c_STOP: begin
        w_cnt_en      = 1'b1;
        w_cnt_clr     = w_at_last;
        w_stop_sample = w_at_last;
      end
      default: begin
        w_cnt_en = 1'b0;
      end
    endcase
  end

  // A low stop bit is reported as a frame error even when parity also failed
  assign w_fe_set    = w_stop_sample && !r_rx_s;
  assign w_byte_load = w_stop_sample && r_rx_s;
  assign w_dv_set    = w_byte_load && !w_par_err;

  always_ff @(posedge i_Clock or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_cnt   <= '0;
      r_idx   <= 3'd0;
      r_shift <= 8'h00;
    end else begin
      if (w_cnt_en && !w_cnt_clr) r_cnt <= r_cnt + 1'b1;
      else                        r_cnt <= '0;
      if (r_state == c_IDLE) begin
        r_idx <= 3'd0;
      end else if (w_shift_we) begin
        r_shift[r_idx] <= r_rx_s;
        r_idx          <= r_idx + 3'd1;
      end
    end
  end

  always_ff @(posedge i_Clock or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_dv     <= 1'b0;
      r_byte   <= 8'h00;
      r_active <= 1'b0;
      r_fe     <= 1'b0;
    end else begin
      r_dv <= w_dv_set;
      r_fe <= w_fe_set;
      if (w_byte_load) r_byte <= r_shift;
      if (w_next_state == c_IDLE) r_active <= 1'b0;
      else if (w_start_ok)        r_active <= 1'b1;
    end
  end

`ifdef UART_RX_PARITY_EN
  logic r_par_err;
  logic r_pe;
  logic w_par_we;
  logic w_pe_set;

  assign w_par_we  = (r_state == c_PARITY) && w_at_last;
  assign w_par_err = r_par_err;
  assign w_pe_set  = w_byte_load && r_par_err;

  // Even parity: data bits XOR parity bit must be zero
  always_ff @(posedge i_Clock or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_par_err <= 1'b0;
      r_pe      <= 1'b0;
    end else begin
      if (r_state == c_IDLE) r_par_err <= 1'b0;
      else if (w_par_we)     r_par_err <= (^r_shift) ^ r_rx_s;
      r_pe <= w_pe_set;
    end
  end

  assign o_RX_Parity_Err = r_pe;
`else
  assign w_par_err       = 1'b0;
  assign o_RX_Parity_Err = 1'b0;
`endif

  assign o_RX_DV        = r_dv;
  assign o_RX_Byte      = r_byte;
  assign o_RX_Active    = r_active;
  assign o_RX_Frame_Err = r_fe;

endmodule

`default_nettype wire

// File: tb/tb_uart_rx.sv
// tb_uart_rx: scoreboard bench for uart_rx at CLKS_PER_BIT=16; parity cases under UART_RX_PARITY_EN.
`timescale 1ns/1ps
`default_nettype none

module tb_uart_rx;

  localparam int CPB = 16;
`ifdef UART_RX_PARITY_EN
  localparam int PAR_EXTRA = CPB;
`else
  localparam int PAR_EXTRA = 0;
`endif
  localparam int K_DV = 0;
  localparam int K_FE = 1;
  localparam int K_PE = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic       dv;
  logic [7:0] rbyte;
  logic       active;
  logic       fe;
  logic       pe;

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .i_Clock        (clk),
    .i_Rst_L        (rst_n),
    .i_RX_Serial    (rx),
    .o_RX_DV        (dv),
    .o_RX_Byte      (rbyte),
    .o_RX_Active    (active),
    .o_RX_Frame_Err (fe),
    .o_RX_Parity_Err(pe)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         kind;
    logic [7:0] b;
    int         at;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail = 0;
  bit   saw_active = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic expect_ev(input int kind, input logic [7:0] b, input int at);
    exp_t e;
    e.kind = kind;
    e.b    = b;
    e.at   = at;
    q.push_back(e);
  endtask

  task automatic drive_bit(input logic v);
    rx = v;
    repeat (CPB) @(negedge clk);
  endtask

  // par < 0 means no parity bit on the wire
  task automatic send_raw(input logic [7:0] b, input int par, input logic stop);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    if (par >= 0) drive_bit(par[0]);
    drive_bit(stop);
  endtask

  task automatic send_ok(input logic [7:0] b);
`ifdef UART_RX_PARITY_EN
    send_raw(b, int'(^b), 1'b1);
`else
    send_raw(b, -1, 1'b1);
`endif
  endtask

  // Monitor: pops one expectation for every strobe the DUT raises
  always @(negedge clk) begin
    if (rst_n) begin
      if (active) saw_active = 1'b1;
      if (dv || fe || pe) begin
        exp_t e;
        int   kind;
        kind = dv ? K_DV : (fe ? K_FE : K_PE);
        check("strobe_exclusive", int'(dv) + int'(fe) + int'(pe), 1);
        if (q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_strobe: got kind %0d byte %0h, expected none", kind, rbyte);
        end else begin
          e = q.pop_front();
          check("strobe_kind", kind, e.kind);
          check("strobe_byte", int'(rbyte), int'(e.b));
          if (e.at != 0) check("strobe_latency", cyc, e.at);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int d;
    rst_n = 1'b0;
    rx    = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (100) @(negedge clk);
    check("idle_dv", int'(dv), 0);
    check("idle_byte", int'(rbyte), 8'h00);
    check("idle_active", int'(active), 0);
    check("idle_fe", int'(fe), 0);
    check("idle_pe", int'(pe), 0);

    // 0xA5 with latency: DV sampled 155 counter ticks after the drive negedge
    saw_active = 1'b0;
    d = cyc;
    expect_ev(K_DV, 8'hA5, d + 155 + PAR_EXTRA);
    send_ok(8'hA5);
    repeat (4) @(negedge clk);
    check("a5_active_seen", int'(saw_active), 1);
    check("a5_active_after", int'(active), 0);

    // Five-clock glitch must not start a frame
    repeat (10) @(negedge clk);
    saw_active = 1'b0;
    rx = 1'b0;
    repeat (5) @(negedge clk);
    rx = 1'b1;
    repeat (30) @(negedge clk);
    check("glitch_active", int'(saw_active), 0);

    // Back-to-back frames
    expect_ev(K_DV, 8'h00, 0);
    expect_ev(K_DV, 8'hFF, 0);
    expect_ev(K_DV, 8'h3C, 0);
    send_ok(8'h00);
    send_ok(8'hFF);
    send_ok(8'h3C);
    repeat (10) @(negedge clk);

    // 0x55 with stop bit low and line held low; byte stays at 0x3C
    expect_ev(K_FE, 8'h3C, 0);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(1'(8'h55 >> i));
`ifdef UART_RX_PARITY_EN
    drive_bit(1'b0);
`endif
    rx = 1'b0;
    repeat (40) @(negedge clk);
    rx = 1'b1;
    repeat (20) @(negedge clk);
    check("fe_byte_held", int'(rbyte), 8'h3C);
    expect_ev(K_DV, 8'h81, 0);
    send_ok(8'h81);
    repeat (10) @(negedge clk);

`ifdef UART_RX_PARITY_EN
    expect_ev(K_DV, 8'h07, 0);
    send_raw(8'h07, 1, 1'b1);
    repeat (5) @(negedge clk);
    expect_ev(K_PE, 8'h07, 0);
    send_raw(8'h07, 0, 1'b1);
    repeat (5) @(negedge clk);
`endif

    // Reset mid-byte aborts silently
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b0);
    rst_n = 1'b0;
    rx    = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_active", int'(active), 0);
    check("rst_byte", int'(rbyte), 8'h00);
    check("rst_dv", int'(dv), 0);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    expect_ev(K_DV, 8'h5A, 0);
    send_ok(8'h5A);
    repeat (40) @(negedge clk);

    check("queue_drained", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
